// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one completed functional-unit result per cycle
// (fixed or rotating priority) and broadcasts it on a registered CDB.
module cdb_arbiter #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ROB_IX_WIDTH = 3,
    parameter int unsigned ROUND_ROBIN  = 1
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           flush_in,
    input  logic [NUM_CH-1:0]              valid_in,
    input  logic [NUM_CH*ROB_IX_WIDTH-1:0] rob_ix_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   value_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   dest_in,
    output logic [NUM_CH-1:0]              read_out,
    output logic                           cdb_valid_out,
    output logic [ROB_IX_WIDTH-1:0]        cdb_rob_ix_out,
    output logic [DATA_WIDTH-1:0]          cdb_value_out,
    output logic [DATA_WIDTH-1:0]          cdb_dest_out
);

    localparam int unsigned IX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IX_W-1:0] LAST_GRANT_RST = IX_W'(NUM_CH - 1);

    logic [IX_W-1:0]         last_grant;
    logic [NUM_CH-1:0]       eligible_c;
    logic                    grant_valid_c;
    logic [IX_W-1:0]         grant_ix_c;
    logic                    grant_c;
    logic [NUM_CH-1:0]       grant_onehot_c;
    logic [ROB_IX_WIDTH-1:0] sel_rob_ix_c;
    logic [DATA_WIDTH-1:0]   sel_value_c;
    logic [DATA_WIDTH-1:0]   sel_dest_c;

    // A channel whose read pulse is high this cycle may still hold valid; mask it.
    assign eligible_c = valid_in & ~read_out;

    // Priority search: lowest index first, or starting one past the last winner.
    always_comb begin : arb_select
        int unsigned     cand;
        logic [IX_W-1:0] cand_ix;
        grant_valid_c = 1'b0;
        grant_ix_c    = '0;
        cand          = 0;
        cand_ix       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ROUND_ROBIN != 0) begin
                cand = (32'(last_grant) + 32'd1 + i) % NUM_CH;
            end else begin
                cand = i;
            end
            cand_ix = IX_W'(cand);
            if (!grant_valid_c && eligible_c[cand_ix]) begin
                grant_valid_c = 1'b1;
                grant_ix_c    = cand_ix;
            end
        end
    end

    assign grant_c        = grant_valid_c & ~flush_in;
    assign grant_onehot_c = NUM_CH'(1) << grant_ix_c;

    // Field mux for the winning channel.
    always_comb begin : field_select
        sel_rob_ix_c = '0;
        sel_value_c  = '0;
        sel_dest_c   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (IX_W'(c) == grant_ix_c) begin
                sel_rob_ix_c = rob_ix_in[c*ROB_IX_WIDTH +: ROB_IX_WIDTH];
                sel_value_c  = value_in[c*DATA_WIDTH +: DATA_WIDTH];
                sel_dest_c   = dest_in[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Registered CDB and read pulse; data holds while the bus is idle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            read_out       <= '0;
            cdb_valid_out  <= 1'b0;
            cdb_rob_ix_out <= '0;
            cdb_value_out  <= '0;
            cdb_dest_out   <= '0;
            last_grant     <= LAST_GRANT_RST;
        end else begin
            cdb_valid_out <= grant_c;
            read_out      <= grant_c ? grant_onehot_c : '0;
            if (grant_c) begin
                cdb_rob_ix_out <= sel_rob_ix_c;
                cdb_value_out  <= sel_value_c;
                cdb_dest_out   <= sel_dest_c;
                last_grant     <= grant_ix_c;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: round-robin, fixed-priority and wide 6-channel
// instances checked against a queue of expected broadcasts.
module tb_cdb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 4-channel round-robin instance
    logic         rr_flush;
    logic [3:0]   rr_valid, rr_read;
    logic [11:0]  rr_rob_in;
    logic [127:0] rr_val_in, rr_dest_in;
    logic         rr_cdb_v;
    logic [2:0]   rr_rob;
    logic [31:0]  rr_val, rr_dest;

    // 4-channel fixed-priority instance
    logic         fx_flush;
    logic [3:0]   fx_valid, fx_read;
    logic [11:0]  fx_rob_in;
    logic [127:0] fx_val_in, fx_dest_in;
    logic         fx_cdb_v;
    logic [2:0]   fx_rob;
    logic [31:0]  fx_val, fx_dest;

    // 6-channel, 64-bit round-robin instance
    logic         w_flush;
    logic [5:0]   w_valid, w_read;
    logic [23:0]  w_rob_in;
    logic [383:0] w_val_in, w_dest_in;
    logic         w_cdb_v;
    logic [3:0]   w_rob;
    logic [63:0]  w_val, w_dest;

    cdb_arbiter #(.NUM_CH(4), .DATA_WIDTH(32), .ROB_IX_WIDTH(3), .ROUND_ROBIN(1)) dut_rr (
        .clk_in(clk), .rst_in(rst), .flush_in(rr_flush), .valid_in(rr_valid),
        .rob_ix_in(rr_rob_in), .value_in(rr_val_in), .dest_in(rr_dest_in),
        .read_out(rr_read), .cdb_valid_out(rr_cdb_v), .cdb_rob_ix_out(rr_rob),
        .cdb_value_out(rr_val), .cdb_dest_out(rr_dest)
    );

    cdb_arbiter #(.NUM_CH(4), .DATA_WIDTH(32), .ROB_IX_WIDTH(3), .ROUND_ROBIN(0)) dut_fx (
        .clk_in(clk), .rst_in(rst), .flush_in(fx_flush), .valid_in(fx_valid),
        .rob_ix_in(fx_rob_in), .value_in(fx_val_in), .dest_in(fx_dest_in),
        .read_out(fx_read), .cdb_valid_out(fx_cdb_v), .cdb_rob_ix_out(fx_rob),
        .cdb_value_out(fx_val), .cdb_dest_out(fx_dest)
    );

    cdb_arbiter #(.NUM_CH(6), .DATA_WIDTH(64), .ROB_IX_WIDTH(4), .ROUND_ROBIN(1)) dut_w (
        .clk_in(clk), .rst_in(rst), .flush_in(w_flush), .valid_in(w_valid),
        .rob_ix_in(w_rob_in), .value_in(w_val_in), .dest_in(w_dest_in),
        .read_out(w_read), .cdb_valid_out(w_cdb_v), .cdb_rob_ix_out(w_rob),
        .cdb_value_out(w_val), .cdb_dest_out(w_dest)
    );

    // Constant per-channel result fields
    function automatic logic [2:0] rob4(input int c);
        return (c == 0) ? 3'd5 : 3'(c);
    endfunction
    function automatic logic [31:0] val4(input int c);
        return (c == 0) ? 32'h0000_1234 : ((32'(c) * 32'h1111_0000) | 32'(c));
    endfunction
    function automatic logic [31:0] dest4(input int c);
        return (c == 1) ? 32'h100 : (c == 3) ? 32'h300 : 32'h0;
    endfunction
    function automatic logic [3:0] robw(input int c);
        return (c == 5) ? 4'd15 : 4'(c + 2);
    endfunction
    function automatic logic [63:0] valw(input int c);
        return (c == 5) ? 64'hDEAD_BEEF_0000_0001 : (64'hA5A5_0000_0000_0000 | 64'(c));
    endfunction
    function automatic logic [63:0] destw(input int c);
        return 64'(c) << 8;
    endfunction

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;

    typedef struct {
        int   dut;
        logic v;
        int   ch;
    } exp_t;
    exp_t exp_q[$];

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int dut, input logic v, input int ch);
        exp_q.push_back('{dut, v, ch});
    endtask

    task automatic check_entry(input exp_t e);
        logic [63:0] ov, ord, orob, oval, odest, erob, eval, edest;
        string       tag;
        tag = $sformatf("s%0d.d%0d", step_no, e.dut);
        case (e.dut)
            0: begin
                ov = 64'(rr_cdb_v); ord = 64'(rr_read); orob = 64'(rr_rob);
                oval = 64'(rr_val); odest = 64'(rr_dest);
                erob = 64'(rob4(e.ch)); eval = 64'(val4(e.ch)); edest = 64'(dest4(e.ch));
            end
            1: begin
                ov = 64'(fx_cdb_v); ord = 64'(fx_read); orob = 64'(fx_rob);
                oval = 64'(fx_val); odest = 64'(fx_dest);
                erob = 64'(rob4(e.ch)); eval = 64'(val4(e.ch)); edest = 64'(dest4(e.ch));
            end
            default: begin
                ov = 64'(w_cdb_v); ord = 64'(w_read); orob = 64'(w_rob);
                oval = w_val; odest = w_dest;
                erob = 64'(robw(e.ch)); eval = valw(e.ch); edest = destw(e.ch);
            end
        endcase
        cmp({tag, ".cdb_valid"}, ov, 64'(e.v));
        cmp({tag, ".read"}, ord, e.v ? (64'd1 << e.ch) : 64'd0);
        if (e.v) begin
            cmp({tag, ".rob_ix"}, orob, erob);
            cmp({tag, ".value"}, oval, eval);
            cmp({tag, ".dest"}, odest, edest);
        end
    endtask

    // One clock edge, then drain the expectations queued for that edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        step_no++;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_entry(e);
        end
    endtask

    task automatic check_rr_zero(input string tag);
        cmp({tag, ".cdb_valid"}, 64'(rr_cdb_v), 64'd0);
        cmp({tag, ".read"}, 64'(rr_read), 64'd0);
        cmp({tag, ".rob_ix"}, 64'(rr_rob), 64'd0);
        cmp({tag, ".value"}, 64'(rr_val), 64'd0);
        cmp({tag, ".dest"}, 64'(rr_dest), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rr_flush = 1'b0; fx_flush = 1'b0; w_flush = 1'b0;
        rr_valid = '0;   fx_valid = '0;   w_valid = '0;
        for (int c = 0; c < 4; c++) begin
            rr_rob_in[c*3 +: 3]   = rob4(c);
            rr_val_in[c*32 +: 32] = val4(c);
            rr_dest_in[c*32 +: 32] = dest4(c);
        end
        fx_rob_in = rr_rob_in; fx_val_in = rr_val_in; fx_dest_in = rr_dest_in;
        for (int c = 0; c < 6; c++) begin
            w_rob_in[c*4 +: 4]    = robw(c);
            w_val_in[c*64 +: 64]  = valw(c);
            w_dest_in[c*64 +: 64] = destw(c);
        end

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_rr_zero("por.rr");
        cmp("por.fx.cdb_valid", 64'(fx_cdb_v), 64'd0);
        cmp("por.w.cdb_valid", 64'(w_cdb_v), 64'd0);
        cmp("por.w.read", 64'(w_read), 64'd0);
        rst = 1'b0;

        // Reset mid-broadcast clears outputs without a clock; ch0 is re-granted
        rr_valid = 4'b0001;
        push_exp(0, 1'b1, 0); tick();
        #1 rst = 1'b1;
        #1 check_rr_zero("mid_rst.rr");
        #1 rst = 1'b0;
        push_exp(0, 1'b1, 0); tick();
        rr_valid = 4'b0000;
        push_exp(0, 1'b0, 0); tick();

        // Fairness from reset: all valid -> 0,1,2,3,0,...
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        rr_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            push_exp(0, 1'b1, k % 4); tick();
        end
        // Two contenders alternate
        rr_valid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            push_exp(0, 1'b1, k % 2); tick();
        end
        rr_valid = 4'b0000;
        push_exp(0, 1'b0, 0); tick();

        // Double-grant guard: ch2 held for three edges
        rr_valid = 4'b0100;
        push_exp(0, 1'b1, 2); tick();
        push_exp(0, 1'b0, 0); tick();
        push_exp(0, 1'b1, 2); tick();
        rr_valid = 4'b0000;
        push_exp(0, 1'b0, 0); tick();

        // Flush squashes a grant and leaves the pointer at ch2
        rr_valid = 4'b0011;
        rr_flush = 1'b1;
        push_exp(0, 1'b0, 0); tick();
        rr_flush = 1'b0;
        push_exp(0, 1'b1, 0); tick();
        push_exp(0, 1'b1, 1); tick();
        rr_valid = 4'b0000;
        push_exp(0, 1'b0, 0); tick();

        // Fixed priority: ch1 then ch2, units dropping valid one cycle after read
        fx_valid = 4'b0110;
        push_exp(1, 1'b1, 1); tick();
        push_exp(1, 1'b1, 2); tick();
        fx_valid = 4'b0100;
        push_exp(1, 1'b0, 0); tick();
        fx_valid = 4'b0000;
        push_exp(1, 1'b0, 0); tick();
        // Lowest index wins regardless of the previous winner
        fx_valid = 4'b1001;
        push_exp(1, 1'b1, 0); tick();
        push_exp(1, 1'b1, 3); tick();
        push_exp(1, 1'b1, 0); tick();
        fx_valid = 4'b0000;
        push_exp(1, 1'b0, 0); tick();

        // Wide instance: 64-bit broadcast of ch5 and wrap from 5 back to 0
        w_valid = 6'b100001;
        push_exp(2, 1'b1, 0); tick();
        push_exp(2, 1'b1, 5); tick();
        push_exp(2, 1'b1, 0); tick();
        w_valid = 6'b000000;
        push_exp(2, 1'b0, 0); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised common-data-bus arbiter for the Tomasulo back end. It takes completed results from NUM_CH functional units (ALU, branch ALU, multiplier, divider, load buffer), grants at most one per cycle, and broadcasts the winner's ROB index, value and destination on a registered CDB that the ROB and all reservation stations snoop. It generalises the earlier two-unit fixed-priority CDB writer with these additions:

- any channel count;
- a selectable round-robin mode;
- double-grant protection;
- a flush input.

## Interface
Parameters:
- NUM_CH, default 4: number of functional-unit channels (≥2).
- DATA_WIDTH, default 32: width of result value and dest.
- ROB_IX_WIDTH, default 3: ROB index width.
- ROUND_ROBIN, default 1: 1 selects rotating priority; 0 selects fixed priority, where the lowest index wins.

Ports:
- clk_in, input, 1: single clock, rising edge.
- rst_in, input, 1: reset, asynchronous, active-high.
- flush_in, input, 1: misprediction flush; squashes arbitration this cycle.
- valid_in, input, NUM_CH: channel c holds a completed result; held high until read.
- rob_ix_in, input, NUM_CH*ROB_IX_WIDTH: packed per-channel ROB index; channel c is at bits [c*ROB_IX_WIDTH +: ROB_IX_WIDTH].
- value_in, input, NUM_CH*DATA_WIDTH: packed per-channel result.
- dest_in, input, NUM_CH*DATA_WIDTH: packed per-channel destination; store address, otherwise 0.
- read_out, output, NUM_CH: one-cycle pulse telling channel c its result was taken.
- cdb_valid_out, output, 1: CDB broadcast valid.
- cdb_rob_ix_out, output, ROB_IX_WIDTH: broadcast ROB index.
- cdb_value_out, output, DATA_WIDTH: broadcast value.
- cdb_dest_out, output, DATA_WIDTH: broadcast destination.

## Operation
- Eligibility in cycle t: eligible[c] = valid_in[c] && !read_out[c].
  - A channel whose read pulse is currently high is excluded, so a unit still holding valid for that cycle is never granted twice.
- Fixed mode picks the lowest-index eligible channel.
- Round-robin mode:
  - Search starts at (last_grant+1) mod NUM_CH and wraps around.
  - last_grant updates to the winner on every grant.
  - last_grant is unchanged when there is no grant.
- On a grant g (no flush), at the next edge:
  - cdb_valid_out←1.
  - cdb_rob_ix_out/value_out/dest_out←channel g's fields.
  - read_out←one-hot(g).
- With no grant, or with flush_in high, at the next edge:
  - cdb_valid_out←0 and read_out←0.
  - Data outputs hold their previous values, which are don't-care while invalid.
- Flush does not alter last_grant.
- The block holds no result storage. A unit keeps its result until it sees read_out.
- Reset values (asynchronous, immediate):
  - read_out=0, cdb_valid_out=0.
  - cdb_rob_ix_out=0, cdb_value_out=0, cdb_dest_out=0.
  - last_grant=NUM_CH-1, so the first round-robin search starts at channel 0.
- Reset mid-broadcast drops cdb_valid_out and read_out at once. A unit that had not yet seen its read pulse keeps valid and is re-arbitrated after reset.

## Timing
- Arbitration is combinational on cycle-t inputs. All outputs are registered, so the CDB and read pulse appear in cycle t+1. Latency from valid_in to broadcast is 1 cycle.
- read_out[g] and cdb_valid_out are high in the same cycle, for exactly one cycle per grant.
- FU handshake:
  - The unit samples read_out at the end of t+1 and must drop or replace valid_in by t+2.
  - valid_in remaining high during t+1 is legal and ignored through the mask.
- Throughput is one broadcast per cycle across the bus. A single channel gets at most one grant every 2 cycles.
- Round-robin fairness: with all channels continuously valid, each channel is granted within NUM_CH cycles.
- Simultaneous flush and valid: no grant. The units are flushed by their own logic.

## Test plan
- Reset to idle:
  - Stimulus: assert rst_in mid-cycle with valid_in=4'b0001.
  - Required: outputs go to 0 immediately, with no clock edge needed. After release, ch0 (rob_ix=5, value=0x1234) appears at the next edge with read_out=0001 for one cycle.
- Fixed priority (ROUND_ROBIN=0):
  - Stimulus: valid_in=4'b0110 held, each unit dropping valid 1 cycle after its read.
  - Required: ch1 is broadcast first, then ch2 the next cycle, then cdb_valid_out=0.
- Round-robin fairness:
  - Stimulus: all 4 valid permanently, re-asserting immediately after each read.
  - Required: grants follow 0,1,2,3,0… with no channel skipped or repeated back-to-back.
  - Required: with only ch0 and ch1 valid, grants alternate 0,1,0,1.
- Double-grant guard:
  - Stimulus: ch2 alone holds valid for 3 cycles with an unchanged result.
  - Required: broadcast at t+1 and t+3, never on consecutive cycles, and read_out[2] is never high for two consecutive cycles.
- Flush:
  - Stimulus: valid_in=0011 with flush_in=1 for one cycle.
  - Required: the next cycle has cdb_valid_out=0 and read_out=0, and last_grant is unchanged.
  - Required: with valid still held after flush, arbitration resumes from the unchanged pointer.
- Width/parameter sweep:
  - Stimulus: NUM_CH=6, DATA_WIDTH=64, ROB_IX_WIDTH=4, ch5 value=0xDEAD_BEEF_0000_0001, rob_ix=15.
  - Required: the broadcast matches bit-exact, and round-robin wraps from 5 to 0.
